// File: rtl/mux2_arbiter.sv
// ============================================================================
// Module      : mux2_arbiter
// Description : Two-requester packet arbiter driving a registered 2:1 stream
//               mux. A grant is held from a packet's first beat until its last
//               beat transfers. Define MUX2_ARBITER_FIXED_PRIO_EN to make A win
//               every IDLE tie; otherwise ties are settled round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2_arbiter #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               a_valid_i,
    input  logic [width_p-1:0] a_data_i,
    input  logic               a_last_i,
    output logic               a_ready_o,
    input  logic               b_valid_i,
    input  logic [width_p-1:0] b_data_i,
    input  logic               b_last_i,
    output logic               b_ready_o,
    output logic               valid_o,
    output logic [width_p-1:0] data_o,
    output logic               last_o,
    output logic               select_o,
    input  logic               ready_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOCK_A = 2'd1,
        S_LOCK_B = 2'd2
    } state_t;

`ifdef MUX2_ARBITER_FIXED_PRIO_EN
    localparam logic c_fixed_prio = 1'b1;
`else
    localparam logic c_fixed_prio = 1'b0;
`endif

    state_t               r_state;
    logic                 r_last_grant;
    logic                 r_valid;
    logic [width_p-1:0]   r_data;
    logic                 r_last;
    logic                 r_select;

    logic                 w_a_wins;
    logic                 w_b_wins;
    logic                 w_grant_a;
    logic                 w_grant_b;
    logic                 w_space;
    logic                 w_accept;
    logic                 w_fire_a;
    logic                 w_fire_b;
    logic                 w_fire;
    logic                 w_fire_last;
    logic [width_p-1:0]   w_fire_data;

    // r_last_grant = 1 means B was served last, so A takes the next tie.
    assign w_a_wins  = a_valid_i & (~b_valid_i | c_fixed_prio | r_last_grant);
    assign w_b_wins  = b_valid_i & ~w_a_wins;

    assign w_grant_a = (r_state == S_LOCK_A) | ((r_state == S_IDLE) & w_a_wins);
    assign w_grant_b = (r_state == S_LOCK_B) | ((r_state == S_IDLE) & w_b_wins);

    // Output slot is free when empty or draining this cycle; nothing is
    // accepted while reset is asserted.
    assign w_space   = ~r_valid | ready_i;
    assign w_accept  = w_space & ~reset_i;

    assign a_ready_o = w_grant_a & w_accept;
    assign b_ready_o = w_grant_b & w_accept;

    assign w_fire_a    = a_ready_o & a_valid_i;
    assign w_fire_b    = b_ready_o & b_valid_i;
    assign w_fire      = w_fire_a | w_fire_b;
    assign w_fire_last = w_fire_b ? b_last_i : a_last_i;
    assign w_fire_data = w_fire_b ? b_data_i : a_data_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_last       <= 1'b0;
            r_select     <= 1'b0;
        end else begin
            if (w_fire) begin
                r_valid  <= 1'b1;
                r_data   <= w_fire_data;
                r_last   <= w_fire_last;
                r_select <= w_fire_b;
                if (w_fire_last) begin
                    r_state      <= S_IDLE;
                    r_last_grant <= w_fire_b;
                end else begin
                    r_state <= w_fire_b ? S_LOCK_B : S_LOCK_A;
                end
            end else if (ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid_o  = r_valid;
    assign data_o   = r_data;
    assign last_o   = r_last;
    assign select_o = r_select;

endmodule

`default_nettype wire
